psram_spi_responder: RTL and testbench

//  SPI-mode-0 responder emulating an IPS6404L-style PSRAM, the device end of the psram controller's bus.

---
 rtl/psram_spi_responder_if.sv | 22 ++
 rtl/psram_spi_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_psram_spi_responder.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_spi_responder_if.sv
// psram_spi_responder_if: SPI bus between a psram controller and the responder.
// Controller drives sclk/ce_n/si; the device drives data and status back.
interface psram_spi_responder_if;
  logic sclk;
  logic ce_n;
  logic si;
  logic so;
  logic so_oe;
  logic busy;
  logic reset_pulse;
  logic cmd_error;

  modport master (
    output sclk, ce_n, si,
    input  so, so_oe, busy, reset_pulse, cmd_error
  );

  modport slave (
    input  sclk, ce_n, si,
    output so, so_oe, busy, reset_pulse, cmd_error
  );
endinterface

// File: rtl/psram_spi_responder.sv
// psram_spi_responder: oversampled SPI mode-0 PSRAM device with a byte array.
// Define PSRAM_RESPONDER_FAST_READ_EN to accept 0Bh (FAST_READ with dummy cycles).
module psram_spi_responder #(
  parameter int          ADDR_BITS = 10,
  parameter logic [7:0]  MFID      = 8'h0D,
  parameter logic [7:0]  KGD       = 8'h5D,
  parameter logic [47:0] EID       = 48'h0123456789AB,
  parameter int          DUMMY_CYC = 8
) (
  input logic sysclk,
  input logic reset,
  psram_spi_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, HOLD, IGNORE,
    RD_DATA, WR_DATA, ID_DATA
`ifdef PSRAM_RESPONDER_FAST_READ_EN
    , DUMMY
`endif
  } state_t;

  logic [2:0] sclk_q;
  logic [2:0] ce_q;
  logic [1:0] si_q;
  logic       sel, rise, fall;
  logic       ce_fall, ce_rise, si_s;

  state_t state, state_n, st_eff;

  logic [2:0] bit_cnt;
  logic [2:0] obit;
  logic [6:0] shreg;
  logic [7:0] new_byte;
  logic [7:0] op;
  logic [7:0] tx;
  logic       byte_done;
  logic       err_set;
  logic       mem_we;
  logic [1:0] acnt;
  logic [ADDR_BITS-1:0] addr, next_addr;
  logic [3:0] id_idx, id_nxt;
  logic       hold_over;
  logic       rst_armed;
  logic       so_r, oe_r, busy_r;
  logic       pulse_r, err_r;
`ifdef PSRAM_RESPONDER_FAST_READ_EN
  logic [7:0] dcnt;
`endif

  logic [7:0] mem [0:DEPTH-1];

  function automatic logic [7:0] id_byte(
    input logic [3:0] i
  );
    logic [7:0] b;
    b = 8'h00;
    if (i == 4'd0) b = MFID;
    else if (i == 4'd1) b = KGD;
    else if (i < 4'd8) b = EID[8*(7-int'(i)) +: 8];
    return b;
  endfunction

  assign sel       = ~ce_q[1];
  assign rise      = sel & sclk_q[1] & ~sclk_q[2];
  assign fall      = sel & ~sclk_q[1] & sclk_q[2];
  assign ce_fall   = ce_q[2] & ~ce_q[1];
  assign ce_rise   = ~ce_q[2] & ce_q[1];
  assign si_s      = si_q[1];
  assign new_byte  = {shreg, si_s};
  assign byte_done = rise & (bit_cnt == 3'd7);
  assign next_addr = ADDR_BITS'({addr, new_byte});
  assign id_nxt    = (id_idx == 4'd8) ? 4'd8 : id_idx + 4'd1;
  assign st_eff    = (state == IDLE && ce_fall) ? CMD : state;
  assign mem_we    = ~reset & ~ce_rise & byte_done
                   & (st_eff == WR_DATA);

  assign bus.so          = so_r;
  assign bus.so_oe       = oe_r;
  assign bus.busy        = busy_r;
  assign bus.reset_pulse = pulse_r;
  assign bus.cmd_error   = err_r;

  // Two-flop synchronizers plus one history stage for edge detection.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sclk_q <= 3'b000;
      ce_q   <= 3'b111;
      si_q   <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.sclk};
      ce_q   <= {ce_q[1:0], bus.ce_n};
      si_q   <= {si_q[0], bus.si};
    end
  end

  // Next-state decode; a ce_n fall is folded in ahead of any sclk edge.
  always_comb begin
    state_n = st_eff;
    err_set = 1'b0;
    if (ce_rise) begin
      state_n = IDLE;
    end else begin
      case (st_eff)
        CMD: if (byte_done) begin
          unique case (1'b1)
            (new_byte == 8'h66),
            (new_byte == 8'h99): state_n = HOLD;
            (new_byte == 8'h9F),
            (new_byte == 8'h03),
            (new_byte == 8'h02): state_n = ADDR;
`ifdef PSRAM_RESPONDER_FAST_READ_EN
            (new_byte == 8'h0B): state_n = ADDR;
`endif
            default: begin
              state_n = IGNORE;
              err_set = 1'b1;
            end
          endcase
        end
        ADDR: if (byte_done && acnt == 2'd2) begin
          unique case (1'b1)
            (op == 8'h9F): state_n = ID_DATA;
            (op == 8'h02): state_n = WR_DATA;
`ifdef PSRAM_RESPONDER_FAST_READ_EN
            (op == 8'h0B): state_n = DUMMY;
`endif
            default:       state_n = RD_DATA;
          endcase
        end
`ifdef PSRAM_RESPONDER_FAST_READ_EN
        DUMMY: if (rise && dcnt == 8'(DUMMY_CYC - 1)) begin
          state_n = RD_DATA;
        end
`endif
        default: ;
      endcase
    end
  end

  // State register, byte assembly, address/readout datapath and status.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      obit      <= '0;
      shreg     <= '0;
      op        <= '0;
      tx        <= '0;
      acnt      <= '0;
      addr      <= '0;
      id_idx    <= '0;
      hold_over <= 1'b0;
      rst_armed <= 1'b0;
      so_r      <= 1'b0;
      oe_r      <= 1'b0;
      busy_r    <= 1'b0;
      pulse_r   <= 1'b0;
      err_r     <= 1'b0;
`ifdef PSRAM_RESPONDER_FAST_READ_EN
      dcnt      <= '0;
`endif
    end else begin
      state   <= state_n;
      busy_r  <= sel;
      pulse_r <= 1'b0;
      if (err_set) err_r <= 1'b1;
      if (ce_rise) begin
        so_r    <= 1'b0;
        oe_r    <= 1'b0;
        bit_cnt <= '0;
        obit    <= '0;
        if (state == HOLD && !hold_over && op == 8'h66) begin
          rst_armed <= 1'b1;
        end else if (state == HOLD && !hold_over
                     && op == 8'h99 && rst_armed) begin
          pulse_r   <= 1'b1;
          rst_armed <= 1'b0;
        end else if (state != IDLE) begin
          rst_armed <= 1'b0;
        end
      end else begin
        if (rise) begin
          shreg   <= new_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (st_eff)
          CMD: if (byte_done) begin
            op        <= new_byte;
            acnt      <= '0;
            hold_over <= 1'b0;
          end
          HOLD: if (rise) hold_over <= 1'b1;
          ADDR: if (byte_done) begin
            addr <= next_addr;
            acnt <= acnt + 2'd1;
            if (acnt == 2'd2) begin
              id_idx <= '0;
`ifdef PSRAM_RESPONDER_FAST_READ_EN
              dcnt   <= '0;
`endif
              if (op == 8'h9F) tx <= MFID;
              else tx <= mem[next_addr];
            end
          end
`ifdef PSRAM_RESPONDER_FAST_READ_EN
          DUMMY: if (rise) begin
            dcnt <= dcnt + 8'd1;
            if (dcnt == 8'(DUMMY_CYC - 1)) tx <= mem[addr];
          end
`endif
          RD_DATA, ID_DATA: if (fall) begin
            so_r <= tx[7];
            oe_r <= 1'b1;
            obit <= obit + 3'd1;
            tx   <= {tx[6:0], 1'b0};
            if (obit == 3'd7) begin
              if (st_eff == ID_DATA) begin
                id_idx <= id_nxt;
                tx     <= id_byte(id_nxt);
              end else begin
                addr <= addr + 1'b1;
                tx   <= mem[addr + 1'b1];
              end
            end
          end
          WR_DATA: if (byte_done) addr <= addr + 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Array write port; contents deliberately have no reset.
  always_ff @(posedge sysclk) begin
    if (mem_we) mem[addr] <= new_byte;
  end
endmodule

// File: tb/tb_psram_spi_responder.sv
// tb_psram_spi_responder: drives SPI mode-0 transactions into the responder
// and compares against a byte-array / reset-arming reference model.
module tb_psram_spi_responder;
  localparam int DEPTH = 1 << 10;
  localparam int HP    = 40;
  localparam logic [7:0]  MFID = 8'h0D;
  localparam logic [7:0]  KGD  = 8'h5D;
  localparam logic [47:0] EID  = 48'h0123456789AB;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   pulses = 0;
  bit   armed  = 1'b0;
  logic [7:0] ref_mem [DEPTH];

  psram_spi_responder_if bus ();

  psram_spi_responder dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #2 sysclk = ~sysclk;

  always @(negedge sysclk)
    if (bus.reset_pulse === 1'b1) pulses++;

  initial begin
    #600000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (4) @(posedge sysclk);
    #1 reset = 1'b0;
    repeat (4) @(posedge sysclk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] d,
                      output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      bus.si = d[i];
      #HP;
      r[i] = bus.so;
      bus.sclk = 1'b1;
      #HP;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic xbits(input logic [7:0] d, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.si = d[i];
      #HP;
      bus.sclk = 1'b1;
      #HP;
      bus.sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.ce_n = 1'b0;
    #HP;
  endtask

  task automatic cs_high();
    #HP;
    bus.ce_n = 1'b1;
    #(2*HP);
  endtask

  task automatic send_hdr(input logic [7:0] op,
                          input logic [23:0] a);
    logic [7:0] r;
    xfer(op, r);
    xfer(a[23:16], r);
    xfer(a[15:8], r);
    xfer(a[7:0], r);
  endtask

  task automatic wr(input logic [23:0] a,
                    input logic [7:0] d[$]);
    logic [7:0] r;
    cs_low();
    send_hdr(8'h02, a);
    foreach (d[k]) begin
      xfer(d[k], r);
      ref_mem[(int'(a) + k) % DEPTH] = d[k];
    end
    cs_high();
  endtask

  task automatic rd(input logic [7:0] op, input logic [23:0] a,
                    input int n, output logic [7:0] q[$]);
    logic [7:0] r;
    q = {};
    cs_low();
    send_hdr(op, a);
    if (op == 8'h0B) xbits(8'h00, 8);
    repeat (n) begin
      xfer(8'h00, r);
      q.push_back(r);
    end
    cs_high();
  endtask

  task automatic test_reset();
    bus.sclk = 1'b0;
    bus.ce_n = 1'b1;
    bus.si   = 1'b0;
    do_reset();
    checks++;
    if (bus.so !== 1'b0) begin
      errors++;
      $display("FAIL reset_so: got %b want 0", bus.so);
    end
    checks++;
    if (bus.so_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_so_oe: got %b want 0", bus.so_oe);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.reset_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse: got %b want 0", bus.reset_pulse);
    end
    checks++;
    if (bus.cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_error: got %b want 0", bus.cmd_error);
    end
    armed = 1'b0;
  endtask

  // -1 encodes "66h followed by one extra bit" (not exactly 8 bits).
  task automatic test_reset_seq();
    int ops[$];
    int p0, expd;
    logic [7:0] r;
    int choice [4] = '{'h66, 'h99, 'h9F, 'h03};
    ops = {'h66, 'h99, 'h99, 'h66, 'h9F, 'h99, -1, 'h99};
    repeat (8) ops.push_back(choice[$urandom_range(0, 3)]);
    foreach (ops[k]) begin
      p0 = pulses;
      cs_low();
      if (ops[k] == -1) begin
        xfer(8'h66, r);
        xbits(8'h80, 1);
      end else if (ops[k] == 'h66 || ops[k] == 'h99) begin
        xfer(8'(ops[k]), r);
      end else begin
        send_hdr(8'(ops[k]), 24'($urandom));
      end
      cs_high();
      expd = (ops[k] == 'h99 && armed) ? 1 : 0;
      armed = (ops[k] == 'h66);
      checks++;
      if (pulses - p0 != expd) begin
        errors++;
        $display("FAIL rst_seq[%0d] op %0h: pulse cycles %0d want %0d",
                 k, ops[k], pulses - p0, expd);
      end
    end
  endtask

  task automatic test_read_id();
    logic [7:0] r, e;
    cs_low();
    send_hdr(8'h9F, 24'hFFFFFF);
    for (int k = 0; k < 9; k++) begin
      xfer(8'h00, r);
      if (k == 0) e = MFID;
      else if (k == 1) e = KGD;
      else if (k < 8) e = 8'(EID >> (8 * (7 - k)));
      else e = 8'h00;
      checks++;
      if (r !== e) begin
        errors++;
        $display("FAIL read_id[%0d]: got %h want %h", k, r, e);
      end
    end
    checks++;
    if (bus.so_oe !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL id_oe_busy: got %b%b want 11",
               bus.so_oe, bus.busy);
    end
    cs_high();
    checks++;
    if (bus.cmd_error !== 1'b0 || bus.so_oe !== 1'b0
        || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL id_after: err/oe/busy %b%b%b want 000",
               bus.cmd_error, bus.so_oe, bus.busy);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] q[$];
    wr(24'h000010, {8'hAB, 8'hCD});
    rd(8'h03, 24'h000010, 2, q);
    checks++;
    if (q[0] !== 8'hAB || q[1] !== 8'hCD) begin
      errors++;
      $display("FAIL wr_rd_fixed: got %h %h want ab cd", q[0], q[1]);
    end
  endtask

  task automatic test_fast_read();
    logic [7:0] q[$];
    rd(8'h0B, 24'h000010, 1, q);
`ifdef PSRAM_RESPONDER_FAST_READ_EN
    checks++;
    if (q[0] !== ref_mem[16] || bus.cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL fast_read: got %h err %b want %h err 0",
               q[0], bus.cmd_error, ref_mem[16]);
    end
`else
    checks++;
    if (bus.cmd_error !== 1'b1) begin
      errors++;
      $display("FAIL fast_read_unknown: cmd_error %b want 1",
               bus.cmd_error);
    end
    do_reset();
    armed = 1'b0;
    checks++;
    if (bus.cmd_error !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: cmd_error %b want 0", bus.cmd_error);
    end
`endif
  endtask

  task automatic test_random_rw();
    logic [7:0] d[$];
    logic [7:0] q[$];
    logic [23:0] a;
    int n;
    repeat (4) begin
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      d = {};
      repeat (n) d.push_back(8'($urandom));
      wr(a, d);
      rd(8'h03, a, n, q);
      foreach (q[k]) begin
        checks++;
        if (q[k] !== ref_mem[(int'(a) + k) % DEPTH]) begin
          errors++;
          $display("FAIL rand_rw a=%h+%0d: got %h want %h", a, k,
                   q[k], ref_mem[(int'(a) + k) % DEPTH]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    wr(24'h0003FF, {8'h11, 8'h22});
    rd(8'h03, 24'h000000, 1, q);
    checks++;
    if (q[0] !== 8'h22) begin
      errors++;
      $display("FAIL wrap_rd0: got %h want 22", q[0]);
    end
    rd(8'h03, 24'h0003FF, 2, q);
    checks++;
    if (q[0] !== 8'h11 || q[1] !== 8'h22) begin
      errors++;
      $display("FAIL wrap_rd3ff: got %h %h want 11 22", q[0], q[1]);
    end
  endtask

  task automatic test_partial_and_error();
    logic [7:0] q[$];
    logic [7:0] r, v;
    v = 8'($urandom);
    wr(24'h000021, {v});
    cs_low();
    send_hdr(8'h02, 24'h000020);
    xfer(8'h55, r);
    ref_mem[32] = 8'h55;
    xbits(8'hFF, 4);
    cs_high();
    rd(8'h03, 24'h000020, 2, q);
    checks++;
    if (q[0] !== 8'h55 || q[1] !== v) begin
      errors++;
      $display("FAIL partial_wr: got %h %h want 55 %h", q[0], q[1], v);
    end
    cs_low();
    xfer(8'h5A, r);
    xfer(8'h00, r);
    checks++;
    if (bus.so_oe !== 1'b0) begin
      errors++;
      $display("FAIL ignore_oe: got %b want 0", bus.so_oe);
    end
    cs_high();
    checks++;
    if (bus.cmd_error !== 1'b1) begin
      errors++;
      $display("FAIL unknown_op: cmd_error %b want 1", bus.cmd_error);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] q[$];
    logic [7:0] x;
    x = 8'($urandom);
    wr(24'h000100, {x});
    cs_low();
    send_hdr(8'h02, 24'h000100);
    xbits(~x, 5);
    reset = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    checks++;
    if (bus.cmd_error !== 1'b0 || bus.so_oe !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: err/oe %b%b want 00",
               bus.cmd_error, bus.so_oe);
    end
    reset = 1'b0;
    armed = 1'b0;
    cs_high();
    rd(8'h03, 24'h000100, 1, q);
    checks++;
    if (q[0] !== x) begin
      errors++;
      $display("FAIL mid_reset_mem: got %h want %h", q[0], x);
    end
  endtask

  initial begin
    test_reset();
    test_reset_seq();
    test_read_id();
    test_write_read();
    test_fast_read();
    test_random_rw();
    test_wrap();
    test_partial_and_error();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
